// File: rtl/bcd_digit_scanner_if.sv
// Display-side bundle for bcd_digit_scanner: load request in, busy/overflow status
// and the multiplexed digit bus out.
interface bcd_digit_scanner_if #(
    parameter int WIDTH  = 14,
    parameter int DIGITS = 4
);
    logic [WIDTH-1:0]  Bin;
    logic              Load;
    logic              Busy;
    logic              Overflow;
    logic [3:0]        DigitOut;
    logic [DIGITS-1:0] DigitSel;

    modport master (
        output Bin, Load,
        input  Busy, Overflow, DigitOut, DigitSel
    );

    modport slave (
        input  Bin, Load,
        output Busy, Overflow, DigitOut, DigitSel
    );
endinterface

// File: rtl/bcd_digit_scanner.sv
// Serial double-dabble binary-to-BCD converter (WIDTH+1 cycles, Load ignored while busy)
// feeding a free-running one-hot digit scanner for a seven-segment decoder.
module bcd_digit_scanner #(
    parameter int WIDTH       = 14,
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 1000
) (
    input  logic clk,
    input  logic rst,
    bcd_digit_scanner_if.slave bus
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);
    localparam int RW = $clog2(REFRESH_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [BW-1:0] DISP_RST = {{(BW-4){1'b1}}, 4'h0};

    function automatic logic [63:0] max_val(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p - 64'd1;
    endfunction

    localparam logic [63:0] MAX_VAL = max_val(DIGITS);

    typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

    state_t                   state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [WIDTH-1:0]         shift_q, shift_d;
    logic [BW-1:0]            bcd_q, bcd_d;
    logic                     oflag_q, oflag_d;
    logic                     ovf_q, ovf_d;
    logic [DIGITS-1:0][3:0]   disp_q, disp_d;

    logic [RW-1:0]            refresh_q, refresh_d;
    logic [IW-1:0]            idx_q, idx_d;
    logic [DIGITS-1:0]        sel_q, sel_d;
    logic [3:0]               dout_q, dout_d;

    logic [BW-1:0]            bcd_adj;
    logic [BW+WIDTH-1:0]      dabble;
    logic [DIGITS-1:0][3:0]   blanked;
    logic                     seen;

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        dabble = {bcd_adj, shift_q} << 1;
    end

    // Digits above the most significant nonzero one are blanked; digit 0 never is.
    always_comb begin
        blanked = bcd_q;
        seen    = 1'b0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (bcd_q[4*i +: 4] != 4'h0) seen = 1'b1;
            if (!seen) blanked[i] = 4'hF;
        end
        if (oflag_q) blanked = {BW{1'b1}};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        bcd_d   = bcd_q;
        oflag_d = oflag_q;
        ovf_d   = ovf_q;
        disp_d  = disp_q;
        case (state_q)
            IDLE: begin
                if (bus.Load) begin
                    shift_d = bus.Bin;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    oflag_d = ({{(64-WIDTH){1'b0}}, bus.Bin} > MAX_VAL);
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                bcd_d   = dabble[BW+WIDTH-1:WIDTH];
                shift_d = dabble[WIDTH-1:0];
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) state_d = COMMIT;
            end
            COMMIT: begin
                disp_d  = blanked;
                ovf_d   = oflag_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            bcd_q   <= '0;
            oflag_q <= 1'b0;
            ovf_q   <= 1'b0;
            disp_q  <= DISP_RST;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            bcd_q   <= bcd_d;
            oflag_q <= oflag_d;
            ovf_q   <= ovf_d;
            disp_q  <= disp_d;
        end
    end

    // Select and digit are both driven from the post-advance index so they switch together.
    always_comb begin
        refresh_d = refresh_q + 1'b1;
        idx_d     = idx_q;
        if (refresh_q == RW'(REFRESH_DIV - 1)) begin
            refresh_d = '0;
            idx_d     = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
        sel_d  = DIGITS'(1) << idx_d;
        dout_d = disp_q[idx_d];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_q <= '0;
            idx_q     <= '0;
            sel_q     <= DIGITS'(1);
            dout_q    <= 4'h0;
        end else begin
            refresh_q <= refresh_d;
            idx_q     <= idx_d;
            sel_q     <= sel_d;
            dout_q    <= dout_d;
        end
    end

    assign bus.Busy     = (state_q != IDLE);
    assign bus.Overflow = ovf_q;
    assign bus.DigitOut = dout_q;
    assign bus.DigitSel = sel_q;
endmodule

// File: tb/tb_bcd_digit_scanner.sv
// Directed bench for bcd_digit_scanner with REFRESH_DIV=4: expected displays are queued
// when a Load is driven and checked against the scanned digit bus after commit.
module tb_bcd_digit_scanner;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   edge_cnt;
    logic [16:0] exp_q[$];

    bcd_digit_scanner_if #(.WIDTH(14), .DIGITS(4)) bus ();

    bcd_digit_scanner #(.WIDTH(14), .DIGITS(4), .REFRESH_DIV(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench's own scanner reference: edges since reset release.
    always @(posedge clk or posedge rst) begin
        if (rst) edge_cnt <= 0;
        else     edge_cnt <= edge_cnt + 1;
    end

    initial begin
        #200us;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic [16:0] model(input int v);
        logic [15:0] r;
        int d;
        bit s;
        if (v > 9999) return {1'b1, 16'hFFFF};
        s = 1'b0;
        r = '0;
        for (int i = 3; i >= 0; i--) begin
            d = (v / (10 ** i)) % 10;
            if (d != 0 || i == 0) s = 1'b1;
            r[4*i +: 4] = s ? 4'(d) : 4'hF;
        end
        return {1'b0, r};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_frame(input logic [15:0] disp);
        int idx;
        repeat (16) begin
            @(negedge clk);
            idx = (edge_cnt / 4) % 4;
            chk("digit_sel", 32'(bus.DigitSel), 32'(1 << idx));
            chk("digit_out", 32'(bus.DigitOut), 32'(disp[4*idx +: 4]));
        end
    endtask

    task automatic do_load(input int v, input bit push);
        @(negedge clk);
        bus.Bin  = 14'(v);
        bus.Load = 1'b1;
        if (push) exp_q.push_back(model(v));
        @(negedge clk);
        bus.Load = 1'b0;
    endtask

    task automatic wait_done(input int start);
        int n;
        logic [16:0] e;
        n = start;
        while (bus.Busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("busy_len", 32'(n), 32'd15);
        if (exp_q.size() == 0) begin
            chk("queue_empty", 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk("overflow", 32'(bus.Overflow), 32'(e[16]));
            check_frame(e[15:0]);
        end
    endtask

    task automatic convert(input int v);
        do_load(v, 1'b1);
        wait_done(0);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        bus.Bin  = '0;
        bus.Load = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(bus.Busy), 32'd0);
        chk("rst_ovf",  32'(bus.Overflow), 32'd0);
        chk("rst_sel",  32'(bus.DigitSel), 32'd1);
        chk("rst_dout", 32'(bus.DigitOut), 32'd0);
        rst = 1'b0;
        check_frame(16'hFFF0);

        convert(1234);
        convert(7);
        convert(0);
        convert(9999);
        convert(1000);
        convert(10000);
        convert(16383);

        do_load(42, 1'b1);
        chk("ovf_hold", 32'(bus.Overflow), 32'd1);
        wait_done(0);

        // Second Load lands mid-conversion and must be dropped.
        do_load(1111, 1'b1);
        repeat (4) @(negedge clk);
        bus.Bin  = 14'd2222;
        bus.Load = 1'b1;
        @(negedge clk);
        bus.Load = 1'b0;
        wait_done(5);
        convert(3456);

        // Reset partway through converting 5678 over a display showing 1234.
        convert(1234);
        do_load(5678, 1'b0);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(bus.Busy), 32'd0);
        chk("mid_rst_ovf",  32'(bus.Overflow), 32'd0);
        chk("mid_rst_sel",  32'(bus.DigitSel), 32'd1);
        chk("mid_rst_dout", 32'(bus.DigitOut), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check_frame(16'hFFF0);
        check_frame(16'hFFF0);
        convert(4321);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
